// File: rtl/win3x3_serializer_pkg.sv
// Shared types and constants for the 3x3 window serializer.
// Bank indices rotate modulo 3 over the three row buffers.
package win_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int WIN_N  = 9;
    localparam int DEF_DW = 8;

    function automatic logic [1:0] bank_next(input logic [1:0] b, input logic [1:0] n);
        logic [2:0] s;
        s = {1'b0, b} + {1'b0, n};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/win3x3_serializer_if.sv
// Pixel-in / window-out stream bundle for win3x3_serializer.
// The slave modport is the serializer's view; master is the feeder/consumer side.
interface win3x3_serializer_if #(
    parameter int DW    = win_pkg::DEF_DW,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              in_pix;
    logic                       out_valid;
    logic [DW-1:0]              out_x;
    logic                       out_last;
    logic [$clog2(IMG_H)-1:0]   out_row;
    logic [$clog2(IMG_W)-1:0]   out_col;
    logic                       frame_done;

    modport master (
        output in_valid, in_pix,
        input  in_ready, out_valid, out_x, out_last, out_row, out_col, frame_done
    );

    modport slave (
        input  in_valid, in_pix,
        output in_ready, out_valid, out_x, out_last, out_row, out_col, frame_done
    );
endinterface

// File: rtl/win3x3_serializer_row_store.sv
// Three-row pixel buffer: one write port and one combinational read port.
// Contents are deliberately left uncleared by reset.
module win_row_store
    import win_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int DW    = DEF_DW,
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [1:0]    wr_bank,
    input  logic [CW-1:0] wr_col,
    input  logic [DW-1:0] wr_pix,
    input  logic [1:0]    rd_bank,
    input  logic [CW-1:0] rd_col,
    output logic [DW-1:0] rd_pix
);

    logic [DW-1:0] mem_q [3][IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_col] <= wr_pix;
        end
    end

    assign rd_pix = mem_q[rd_bank][rd_col];

endmodule

// File: rtl/win3x3_serializer.sv
// Raster pixel stream to serialized 3x3 windows (row-major, 9-cycle bursts).
// state | meaning
// FILL  | accepting pixels into the row store
// EMIT  | streaming the latched window, k = 0..8, input stalled
module win3x3_serializer
    import win_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = DEF_DW
) (
    input  logic               clk,
    input  logic               reset,
    win3x3_serializer_if.slave bus
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, base_q, base_d, cen_col_q, cen_col_d;
    logic [RW-1:0] row_q, row_d, cen_row_q, cen_row_d;
    logic [1:0]    bank_q, bank_d, top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [3:0]    k_q, k_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          frame_done_q, frame_done_d;
    logic [DW-1:0] out_x_q, out_x_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;

    logic          accept, completes;
    logic [1:0]    k_row, k_col, rd_bank;
    logic [CW-1:0] rd_col;
    logic [DW-1:0] rd_pix;

    assign bus.in_ready = (state_q == FILL) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign completes    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign k_row  = 2'(k_q / 4'd3);
    assign k_col  = 2'(k_q % 4'd3);
    assign rd_col = base_q + CW'(k_col);

    always_comb begin
        case (k_row)
            2'd0:    rd_bank = top_q;
            2'd1:    rd_bank = mid_q;
            default: rd_bank = bot_q;
        endcase
    end

    win_row_store #(.IMG_W(IMG_W), .DW(DW)) u_store (
        .clk     (clk),
        .wr_en   (accept),
        .wr_bank (bank_q),
        .wr_col  (col_q),
        .wr_pix  (bus.in_pix),
        .rd_bank (rd_bank),
        .rd_col  (rd_col),
        .rd_pix  (rd_pix)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        bank_d       = bank_q;
        base_d       = base_q;
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        cen_row_d    = cen_row_q;
        cen_col_d    = cen_col_q;
        k_d          = k_q;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        frame_done_d = 1'b0;
        out_x_d      = '0;
        out_row_d    = '0;
        out_col_d    = '0;

        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d  = '0;
                    bank_d = 2'd0;
                end else begin
                    row_d  = row_q + RW'(1);
                    bank_d = bank_next(bank_q, 2'd1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        // The current bank is the bottom row; the two before it, oldest first, sit above.
        if (completes) begin
            base_d    = col_q - CW'(2);
            top_d     = bank_next(bank_q, 2'd1);
            mid_d     = bank_next(bank_q, 2'd2);
            bot_d     = bank_q;
            cen_row_d = row_q - RW'(1);
            cen_col_d = col_q - CW'(1);
            k_d       = '0;
            state_d   = EMIT;
        end

        if (state_q == EMIT) begin
            out_valid_d = 1'b1;
            out_x_d     = rd_pix;
            out_row_d   = cen_row_q;
            out_col_d   = cen_col_q;
            if (k_q == 4'(WIN_N - 1)) begin
                out_last_d   = 1'b1;
                frame_done_d = (cen_row_q == RW'(IMG_H - 2)) && (cen_col_q == CW'(IMG_W - 2));
                k_d          = '0;
                state_d      = FILL;
            end else begin
                k_d = k_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            bank_q       <= '0;
            base_q       <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            cen_row_q    <= '0;
            cen_col_q    <= '0;
            k_q          <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            out_x_q      <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            bank_q       <= bank_d;
            base_q       <= base_d;
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            cen_row_q    <= cen_row_d;
            cen_col_q    <= cen_col_d;
            k_q          <= k_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            out_x_q      <= out_x_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.frame_done = frame_done_q;

endmodule
